// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types for the timer front end (control FSM states).
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Control FSM encoding shared by the tick generator and any observers.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } timer_state_t;

endpackage : timer_pkg
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : 2-flop synchronizer, stability-count debouncer and registered
//                rising-edge detect. Produces a one-cycle press pulse; releases
//                produce nothing.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
  import timer_pkg::*;
#(
  parameter int DB_CNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int            CW        = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [CW-1:0] C_CNT_MAX = CW'(DB_CNT - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_db_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Two-stage synchronizer for the asynchronous raw button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  // Debounced level follows the synchronized level only after DB_CNT
  // consecutive mismatching cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_db  <= 1'b0;
    end else if (r_sync2 == r_db) begin
      r_cnt <= '0;
    end else if (r_cnt == C_CNT_MAX) begin
      r_cnt <= '0;
      r_db  <= r_sync2;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered rising-edge detect on the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_db_d  <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_db_d  <= r_db;
      r_press <= r_db & ~r_db_d;
    end
  end

  assign press = r_press;

endmodule : btn_debounce
`default_nettype wire

// File: rtl/timer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : timer_tick_gen
//  Description : Timer chain front end. Debounces start/stop and clear
//                buttons, runs the IDLE/RUN/PAUSE control FSM and divides clk
//                into a one-cycle tick every DIV clocks while running.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_tick_gen
  import timer_pkg::*;
#(
  parameter int DIV    = 500000,
  parameter int DB_CNT = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_ss,
  input  logic btn_clr,
  output logic tick,
  output logic running,
  output logic clr
);

  localparam int            PW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] C_PRE_MAX = PW'(DIV - 1);

  logic          w_ss_press;
  logic          w_clr_press;

  timer_state_t  r_state;
  timer_state_t  w_state_nxt;
  logic [PW-1:0] r_pre;
  logic [PW-1:0] w_pre_nxt;
  logic          r_tick;
  logic          w_tick_nxt;
  logic          r_running;
  logic          w_running_nxt;
  logic          r_clr;
  logic          w_clr_nxt;

  btn_debounce #(
    .DB_CNT (DB_CNT)
  ) u_db_ss (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_ss),
    .press (w_ss_press)
  );

  btn_debounce #(
    .DB_CNT (DB_CNT)
  ) u_db_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clr),
    .press (w_clr_press)
  );

  // State, prescaler and output strobes all update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pre     <= '0;
      r_tick    <= 1'b0;
      r_running <= 1'b0;
      r_clr     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pre     <= w_pre_nxt;
      r_tick    <= w_tick_nxt;
      r_running <= w_running_nxt;
      r_clr     <= w_clr_nxt;
    end
  end

  // Next state and prescaler; clear beats start/stop, and any acted-on press
  // freezes the prescaler and suppresses the tick on that edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_tick_nxt  = 1'b0;
    w_clr_nxt   = 1'b0;

    if (w_clr_press) begin
      w_state_nxt = IDLE;
      w_pre_nxt   = '0;
      w_clr_nxt   = 1'b1;
    end else if (w_ss_press) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: begin
          w_state_nxt = IDLE;
          w_pre_nxt   = '0;
        end
      endcase
    end else begin
      case (r_state)
        IDLE:    w_pre_nxt = '0;
        RUN: begin
          if (r_pre == C_PRE_MAX) begin
            w_pre_nxt  = '0;
            w_tick_nxt = 1'b1;
          end else begin
            w_pre_nxt  = r_pre + 1'b1;
          end
        end
        PAUSE:   w_pre_nxt = r_pre;
        default: begin
          w_state_nxt = IDLE;
          w_pre_nxt   = '0;
        end
      endcase
    end

    w_running_nxt = (w_state_nxt == RUN);
  end

  assign tick    = r_tick;
  assign running = r_running;
  assign clr     = r_clr;

endmodule : timer_tick_gen
`default_nettype wire

// File: tb/tb_timer_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_tick_gen
//  Description : Directed self-checking bench for timer_tick_gen with DIV=5,
//                DB_CNT=4. A cycle table covers start, pause and resume;
//                hand sequences cover bounce, clear priority, held button and
//                asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_tick_gen;

  localparam int DIV    = 5;
  localparam int DB_CNT = 4;
  localparam int NVEC   = 80;

  logic clk;
  logic rst_n;
  logic btn_ss;
  logic btn_clr;
  logic tick;
  logic running;
  logic clr;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic ss;
    logic cl;
    logic e_tick;
    logic e_run;
    logic e_clr;
  } vec_t;

  vec_t tbl [NVEC];

  timer_tick_gen #(
    .DIV    (DIV),
    .DB_CNT (DB_CNT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_ss  (btn_ss),
    .btn_clr (btn_clr),
    .tick    (tick),
    .running (running),
    .clr     (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int k, input logic et, input logic er, input logic ec);
    chk($sformatf("%s.tick[%0d]", tag, k), {31'd0, tick}, {31'd0, et});
    chk($sformatf("%s.running[%0d]", tag, k), {31'd0, running}, {31'd0, er});
    chk($sformatf("%s.clr[%0d]", tag, k), {31'd0, clr}, {31'd0, ec});
  endtask

  // Drive inputs for the coming edge, then sample just after it.
  task automatic cyc(input logic ss, input logic cl);
    btn_ss  = ss;
    btn_clr = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int   n_trans;
    logic prev_run;
    logic found;

    rst_n   = 1'b0;
    btn_ss  = 1'b0;
    btn_clr = 1'b0;

    // Start at i=0 (E0), pause press sampled at 28 (pause edge 35, prescaler
    // 2), resume press sampled at 56 (resume edge 63, first tick 3 later).
    for (int i = 0; i < NVEC; i++) begin
      tbl[i].ss     = (i < 10) || (i >= 28 && i < 36) || (i >= 56 && i < 64);
      tbl[i].cl     = 1'b0;
      tbl[i].e_run  = (i >= 7 && i < 35) || (i >= 63);
      tbl[i].e_tick = (i == 12) || (i == 17) || (i == 22) || (i == 27) ||
                      (i == 32) || (i == 66) || (i == 71) || (i == 76);
      tbl[i].e_clr  = 1'b0;
    end

    #12;
    chk_out("reset", 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 1'b0);
      chk_out("idle", k, 1'b0, 1'b0, 1'b0);
    end

    // Bounce: highs of 2 and 3 cycles split by single-cycle lows.
    for (int k = 0; k < 40; k++) begin
      int ph;
      ph = k % 7;
      cyc((ph != 2) && (ph != 6), 1'b0);
      chk_out("bounce", k, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0);
      chk_out("bounce_settle", k, 1'b0, 1'b0, 1'b0);
    end

    // Start, steady ticks, pause and resume.
    for (int i = 0; i < NVEC; i++) begin
      cyc(tbl[i].ss, tbl[i].cl);
      chk_out("tbl", i, tbl[i].e_tick, tbl[i].e_run, tbl[i].e_clr);
    end

    // Clear and start/stop pressed together while running; prescaler is at 3.
    for (int k = 0; k < 21; k++) begin
      cyc(k < 8, k < 8);
      chk_out("clr_prio", k, (k == 1) || (k == 6), k < 7, k == 7);
    end

    // Restart after clear must see a full first period.
    for (int k = 0; k < 20; k++) begin
      cyc(k < 8, 1'b0);
      chk_out("restart", k, (k == 12) || (k == 17), k >= 7, 1'b0);
    end

    // Back to IDLE with a clear press; prescaler is at 2.
    for (int k = 0; k < 16; k++) begin
      cyc(1'b0, k < 8);
      chk_out("clr_idle", k, k == 2, k < 7, k == 7);
    end

    // Held button: one transition only, release does nothing.
    n_trans  = 0;
    prev_run = running;
    for (int k = 0; k < 130; k++) begin
      cyc(k < 100, 1'b0);
      chk_out("held", k, (k >= 12) && ((k - 12) % 5 == 0), k >= 7, 1'b0);
      if (running !== prev_run) n_trans++;
      prev_run = running;
    end
    chk("held.transitions", n_trans, 1);

    // Asynchronous reset asserted between edges while tick is high.
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cyc(1'b0, 1'b0);
      if (tick === 1'b1) found = 1'b1;
    end
    chk("areset.tick_seen", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_out("areset", 0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_out("areset_hold", 0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b0);
      chk_out("post_reset", k, 1'b0, 1'b0, 1'b0);
    end
    for (int k = 0; k < 20; k++) begin
      cyc(k < 8, 1'b0);
      chk_out("post_reset_start", k, (k == 12) || (k == 17), k >= 7, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_timer_tick_gen
`default_nettype wire

// File: doc/timer_tick_gen.md
# timer_tick_gen

Front end of the timer chain. Debounces the raw start/stop and clear push-buttons and runs a RUN/PAUSE/IDLE control FSM. While running, it divides `clk` down to a one-cycle `tick` strobe every `DIV` clocks. `tick` drives the enable input of the first decade-counter stage, and `clr` gives downstream logic a synchronous clear strobe.

## Interface
- `DIV`, default 500000: clocks per tick (10 ms at 50 MHz); legal range ≥ 2.
- `DB_CNT`, default 500000: consecutive stable cycles required before a debounced level changes; legal range ≥ 2.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_ss`  in  1  raw start/stop button, active-high, asynchronous to `clk`.
- `btn_clr`  in  1  raw clear button, active-high, asynchronous to `clk`.
- `tick`  out  1  one-cycle strobe every `DIV` clocks while in RUN.
- `running`  out  1  high while the FSM is in RUN.
- `clr`  out  1  one-cycle strobe on an accepted clear press.

## Operation
- **Button path (per button):**
  - 2-flop synchronizer.
  - Debounce counter is reset to 0 whenever the synchronized level equals the debounced level; otherwise it increments.
  - The debounced level takes the synchronized value on the edge where the counter equals `DB_CNT-1` and the mismatch still holds.
  - A registered rising-edge detect on the debounced level yields a one-cycle `press` pulse.
  - Releases generate nothing.
- **FSM states:** IDLE, RUN, PAUSE.
  - IDLE: prescaler = 0. `ss` press → RUN.
  - RUN: prescaler counts 0..`DIV-1` and wraps to 0. `ss` press → PAUSE, and the prescaler holds its value.
  - PAUSE: prescaler holds. `ss` press → RUN, resuming from the held value.
  - Any state: `clr` press → IDLE, prescaler forced to 0, `clr` output pulses.
- **Simultaneous `clr` and `ss` presses:** `clr` wins and `ss` is discarded.
- **`tick`:** registered. High for exactly one cycle after an edge at which state = RUN, no press is acted on, and prescaler = `DIV-1`.
  - At the edge that leaves RUN, the tick is suppressed. If that happens while the prescaler = `DIV-1`, the prescaler holds at `DIV-1`.
- **`running`:** registered, equal to (next state == RUN).
- **Prescaler width:** `$clog2(DIV)`. No other value is ever reached.

## Timing
- **Reset values:**
  - `tick` = 0, `running` = 0, `clr` = 0.
  - State = IDLE, prescaler = 0.
  - Synchronizers, debounced levels and edge registers = 0.
  - Debounce counters = 0.
- **Button latency:** a raw rising edge is first sampled at edge E0. Then:
  - the debounced level changes at E0+1+`DB_CNT`;
  - `press` is high after E0+2+`DB_CNT`;
  - the FSM state, `running` and `clr` update at E0+3+`DB_CNT`.
- **Tick period:** exactly `DIV` clocks in steady RUN.
  - The first tick after IDLE→RUN occurs `DIV` edges after the RUN entry edge.
  - The first tick after PAUSE→RUN occurs (`DIV-1` − held value) + 1 edges after the resume edge.
- **Glitch rejection:** a synchronized level held fewer than `DB_CNT` cycles produces no change.
- **Held button:** a button held indefinitely produces exactly one `press`.
- **Reset mid-operation:** `rst_n` low clears all state immediately and asynchronously. No `tick` or `clr` is emitted during or after reset until a new press.

## Structure
- **Shared package `timer_pkg`:** state typedef `timer_state_t` with IDLE=2'b00, RUN=2'b01, PAUSE=2'b10.
- **Sub-module `btn_debounce`:** parameter `DB_CNT`; ports `clk`, `rst_n`, `btn`, `press`. It contains the synchronizer, the debounce counter and the edge detect, and is instantiated twice.
- **Top-level contents:** FSM, prescaler, and the `tick`/`running`/`clr` registers.

## Test plan
Bench parameters: `DIV`=5, `DB_CNT`=4.
- **Start:** clean `btn_ss` pulse held 10 cycles → `running` rises at E0+7; `tick` pulses every 5 cycles, first at 5 edges after RUN entry; exactly one tick per period.
- **Bounce:** `btn_ss` toggled with high phases of 2–3 cycles separated by 1-cycle lows, 40 cycles → no state change, `tick`=0 throughout.
- **Pause/resume:** pause at prescaler=2, hold 20 cycles → no `tick`, `running`=0. Resume → first `tick` 3 edges after the resume edge, then period 5.
- **Clear priority:** `btn_clr` and `btn_ss` pressed on the same cycle while in RUN → IDLE, one `clr` pulse, `running`=0, no `tick`, prescaler=0; the next `ss` press restarts with a full 5-cycle first period.
- **Held button:** `btn_ss` held 100 cycles from IDLE → exactly one transition to RUN; release produces no transition.
- **Async reset:** `rst_n` pulled low mid-RUN between clock edges → `tick`, `running`, `clr` = 0 immediately; after release, state stays IDLE with no ticks until a press.
